i2s_tx: RTL and testbench
=========================

# i2s_tx

I2S transmitter: serialises parallel stereo PCM samples into standard I2S (BCK, LRCK, SDATA) generated from the 50 MHz system clock. It is the source end of the I2S link the converter chain receives. It drives the bench/loopback input of the I2S-to-TDA1540 path and serves as an on-board test source. A one-entry holding buffer with a valid/ready handshake decouples the sample producer from frame timing.

## Interface
- `HALF_DIV`, default 8: `in_clk` cycles per BCK half-period. Legal range ≥2. 8 gives BCK 3.125 MHz and fs 48.828 kHz.
- `DATA_W`, default 24: sample width per channel. Legal range 16..32.
- `in_clk`, input, 1 bit: system clock, 50 MHz. Everything is clocked on its rising edge.
- `in_rst`, input, 1 bit: reset, synchronous, active-high.
- `in_left`, input, `DATA_W` bits: left sample, two's complement.
- `in_right`, input, `DATA_W` bits: right sample, two's complement.
- `in_valid`, input, 1 bit: the sample pair is valid.
- `out_ready`, output, 1 bit: the holding buffer is empty and can accept a pair.
- `out_bck`, output, 1 bit: I2S bit clock.
- `out_lrck`, output, 1 bit: word select. 0 = left, 1 = right.
- `out_sdata`, output, 1 bit: serial data, MSB first.
- `out_underrun`, output, 1 bit: one-cycle pulse when a frame starts with an empty buffer.

## Operation
- **Divider:** `div_cnt` counts 0..`HALF_DIV`-1. On terminal count it wraps to 0 and `out_bck` toggles.
  - A toggle 1→0 is a *fall event*.
  - A toggle 0→1 is a *rise event*.
- **Frame:** 64 BCK long, 32 BCK slots per channel. `bit_cnt` (6 bits) increments mod 64 on each fall event.
- **LRCK:** `out_lrck` = `bit_cnt[5]` of the new value, updated on the fall event.
  - Low for `bit_cnt` 0..31.
  - High for `bit_cnt` 32..63.
- **Slot layout:** I2S one-BCK delay. In slot position s = `bit_cnt[4:0]`:
  - s=1..`DATA_W` carry sample bits MSB..LSB.
  - All other positions carry 0. If `DATA_W`=32, position 0 of the next slot carries the LSB.
- **Shift register:** 64-bit, loaded as {left, zero-pad to 32, right, zero-pad to 32}. `out_sdata` is its MSB. It shifts left by one on every fall event except the load event. The one-cycle-late register output provides the delay.
- **Buffer and handshake:**
  - `out_ready` = buffer empty.
  - Capture happens on `in_valid` && `out_ready`. The buffer then becomes full and `out_ready` drops on the next cycle.
  - `in_valid` while not ready is ignored. The producer holds its data.
- **Frame load event:** the fall event where `bit_cnt` wraps 63→0.
  - Buffer full: the shift register loads the buffer, and the buffer empties.
  - Buffer empty: the shift register loads zeros and `out_underrun` pulses for exactly that cycle.
- **Simultaneous load and capture:**
  - Buffer full: the old contents are transmitted. The new pair is not captured (`out_ready` was 0).
  - Buffer empty with `in_valid`=1: the pair is captured into the buffer and sent next frame. The current frame underruns.
- **Reset:**
  - Values: `div_cnt`=0, `bit_cnt`=63, `out_bck`=0, `out_lrck`=1, `out_sdata`=0, shift register 0, buffer empty, `out_ready`=1, `out_underrun`=0.
  - A mid-frame reset aborts the frame immediately and discards buffer contents.

## Timing
- BCK period is 2·`HALF_DIV` `in_clk` cycles. After reset deassertion the first rise occurs at cycle `HALF_DIV` and the first fall at 2·`HALF_DIV`.
- The first fall after reset is a frame load event: `bit_cnt` goes 63→0 and LRCK falls.
- `out_lrck` and `out_sdata` change only on the `in_clk` edge of a fall event. They are stable across every rise event.
- Latency: a pair accepted before a load event appears with its left MSB one BCK after that event. The first sample bit follows the load event by 2·`HALF_DIV` cycles.
- Throughput: one pair per 64 BCK (128·`HALF_DIV` cycles).

## Configuration
- `I2S_TX_REPEAT_ON_UNDERRUN_EN` defined: on underrun the shift register reloads the last transmitted pair. `out_underrun` still pulses. Zeros are sent only when no pair has been sent since reset.
- Undefined: underrun frames are all-zero (digital silence).

## Test plan
- **Reset:** hold `in_rst` 3 cycles → all outputs at their reset values. The first `out_bck` rise comes 8 cycles after release (`HALF_DIV`=8) and the period is 16 cycles.
- **Single pair:** left=24'hABCDEF, right=24'h123456 before the first load. The bits sampled on rises at `bit_cnt`=1..24 equal ABCDEF MSB-first, and at 33..56 equal 123456. All other positions are 0. `out_lrck` is 0 then 1.
- **Handshake:** hold `in_valid` with successive pairs → `out_ready` falls one cycle after capture and reasserts the cycle after each load event. Exactly one pair is accepted per frame, with no loss or duplication over 4 frames.
- **Underrun:** send no data after one pair → the next frame carries all-zero `out_sdata` (with the macro, a repeat of the prior pair). `out_underrun` is high for exactly 1 cycle at the load event.
- **Simultaneous:** assert `in_valid` on the exact load-event cycle with the buffer empty → `out_underrun` pulses and the pair appears in the following frame.
- **Mid-frame reset:** assert `in_rst` at `bit_cnt`=40 → outputs return to reset values next cycle and the buffered pair is dropped (the first frame after release is all-zero with an underrun pulse).

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry holding buffer feeding a 64-BCK stereo frame, BCK/LRCK derived from in_clk.
// Optional I2S_TX_REPEAT_ON_UNDERRUN_EN: an underrun frame repeats the last transmitted pair instead of silence.
module i2s_tx #(
    parameter int HALF_DIV = 8,
    parameter int DATA_W   = 24
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
    output logic              out_ready,
    output logic              out_bck,
    output logic              out_lrck,
    output logic              out_sdata,
    output logic              out_underrun
);

    localparam int DIV_W = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_cnt_nxt;
    logic [63:0]      shift_reg;
    logic [63:0]      buf_pair;
    logic [63:0]      reload_pair;
    logic             buf_full;
    logic             div_tc;
    logic             fall_evt;
    logic             load_evt;
    logic             capture;

    // Frame layout: each channel left-justified in its 32-bit slot, zero padded below.
    function automatic logic [63:0] pack_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        logic [63:0] p;
        p           = '0;
        p[63 -: DATA_W] = l;
        p[31 -: DATA_W] = r;
        return p;
    endfunction

    assign div_tc      = (div_cnt == DIV_W'(HALF_DIV - 1));
    assign fall_evt    = div_tc && out_bck;
    assign load_evt    = fall_evt && (bit_cnt == 6'd63);
    assign capture     = in_valid && !buf_full;
    assign bit_cnt_nxt = bit_cnt + 6'd1;
    assign out_ready   = !buf_full;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [63:0] last_pair;

    always_ff @(posedge in_clk) begin
        if (in_rst)
            last_pair <= '0;
        else if (load_evt && buf_full)
            last_pair <= buf_pair;
    end

    always_comb begin
        // NOTE: combinational outputs get a default first so no path can infer a latch.
        reload_pair = last_pair;
        if (buf_full)
            reload_pair = buf_pair;
    end
`else
    always_comb begin
        reload_pair = '0;
        if (buf_full)
            reload_pair = buf_pair;
    end
`endif

    // NOTE: buffer payload is not reset; buf_full alone decides whether it is ever used.
    always_ff @(posedge in_clk) begin
        if (capture)
            buf_pair <= pack_pair(in_left, in_right);
    end

    always_ff @(posedge in_clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (in_rst) begin
            div_cnt      <= '0;
            bit_cnt      <= 6'd63;
            out_bck      <= 1'b0;
            out_lrck     <= 1'b1;
            out_sdata    <= 1'b0;
            shift_reg    <= '0;
            buf_full     <= 1'b0;
            out_underrun <= 1'b0;
        end else begin
            out_underrun <= load_evt && !buf_full;

            if (div_tc) begin
                div_cnt <= '0;
                out_bck <= ~out_bck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall_evt) begin
                bit_cnt  <= bit_cnt_nxt;
                out_lrck <= bit_cnt_nxt[5];
                // Registering the MSB here gives the one-BCK I2S delay after the load.
                out_sdata <= shift_reg[63];
                if (load_evt)
                    shift_reg <= reload_pair;
                else
                    shift_reg <= {shift_reg[62:0], 1'b0};
            end

            if (load_evt && buf_full)
                buf_full <= 1'b0;
            else if (capture)
                buf_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected frames, a monitor reassembles frames from BCK rises.
module tb_i2s_tx;

    localparam int HALF_DIV = 8;
    localparam int DATA_W   = 24;

    typedef struct {
        logic [63:0] frame;
        bit          ur;
    } exp_t;

    logic              in_clk = 1'b0;
    logic              in_rst = 1'b1;
    logic [DATA_W-1:0] in_left = '0;
    logic [DATA_W-1:0] in_right = '0;
    logic              in_valid = 1'b0;
    logic              out_ready;
    logic              out_bck;
    logic              out_lrck;
    logic              out_sdata;
    logic              out_underrun;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    i2s_tx #(.HALF_DIV(HALF_DIV), .DATA_W(DATA_W)) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .out_bck     (out_bck),
        .out_lrck    (out_lrck),
        .out_sdata   (out_sdata),
        .out_underrun(out_underrun)
    );

    always #5 in_clk = ~in_clk;

    // Posedges since reset release; the first edge after release is 1.
    always @(posedge in_clk) cyc <= in_rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mk(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        logic [63:0] e;
        e           = '0;
        e[62 -: DATA_W] = l;
        e[30 -: DATA_W] = r;
        return e;
    endfunction

    task automatic tick();
        @(posedge in_clk);
        #2;
    endtask

    task automatic wait_until(input int k);
        for (int i = 0; i < 20000 && cyc < k; i++)
            tick();
        check("wait_until_reached", cyc, k);
    endtask

    task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, output int cap);
        bit ok;
        bit rdy;
        ok       = 1'b0;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            rdy = out_ready;
            tick();
            if (rdy)
                ok = 1'b1;
        end
        in_valid = 1'b0;
        cap      = cyc;
        check("send_accepted", ok, 1);
        check("ready_drop_after_capture", out_ready, 0);
    endtask

    // Monitor: tracks BCK edges independently, samples SDATA on rises, compares whole frames.
    initial begin : monitor
        logic        prev_bck;
        logic [5:0]  pos;
        logic [63:0] got;
        bit          in_frame;
        bit          have_rise;
        int          last_rise;
        int          uc;
        exp_t        e;
        prev_bck = 1'b0; pos = 6'd63; got = '0; in_frame = 0; have_rise = 0; last_rise = 0; uc = 0;
        forever begin
            @(negedge in_clk);
            if (in_rst) begin
                prev_bck = 1'b0; pos = 6'd63; got = '0; in_frame = 0; have_rise = 0; uc = 0;
            end else begin
                if (prev_bck && !out_bck) begin
                    pos = pos + 6'd1;
                    if (pos == 6'd0) begin
                        in_frame = 1;
                        got      = '0;
                        uc       = out_underrun ? 1 : 0;
                    end else if (out_underrun) begin
                        uc++;
                    end
                end else if (out_underrun) begin
                    uc++;
                end
                if (!prev_bck && out_bck) begin
                    if (!have_rise)
                        check("first_rise_cycle", cyc, HALF_DIV);
                    else
                        check("bck_period", cyc - last_rise, 2 * HALF_DIV);
                    have_rise = 1;
                    last_rise = cyc;
                    check("lrck_vs_slot", out_lrck, pos[5]);
                    got[63 - pos] = out_sdata;
                    if (in_frame && pos == 6'd63) begin
                        check("frame_expected_present", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("frame_data", got, e.frame);
                            check("frame_underrun_pulses", uc, e.ur ? 1 : 0);
                        end
                    end
                end
                prev_bck = out_bck;
            end
        end
    end

    initial begin : stimulus
        int          c;
        logic [63:0] last_tx;
        logic [63:0] ur_frame;
        last_tx = '0;

        in_rst = 1'b1;
        repeat (3) tick();
        check("rst_bck", out_bck, 0);
        check("rst_lrck", out_lrck, 1);
        check("rst_sdata", out_sdata, 0);
        check("rst_ready", out_ready, 1);
        check("rst_underrun", out_underrun, 0);
        in_rst = 1'b0;

        // Single pair before the first load, then back-to-back pairs with valid held.
        send(24'hABCDEF, 24'h123456, c); check("cap_cycle_p1", c, 1);
        sb.push_back('{mk(24'hABCDEF, 24'h123456), 1'b0}); last_tx = mk(24'hABCDEF, 24'h123456);
        send(24'h800001, 24'h7FFFFE, c); check("cap_cycle_p2", c, 17);
        sb.push_back('{mk(24'h800001, 24'h7FFFFE), 1'b0}); last_tx = mk(24'h800001, 24'h7FFFFE);
        send(24'h000001, 24'hFFFFFF, c); check("cap_cycle_p3", c, 1041);
        sb.push_back('{mk(24'h000001, 24'hFFFFFF), 1'b0}); last_tx = mk(24'h000001, 24'hFFFFFF);
        send(24'h5A5A5A, 24'hA5A5A5, c); check("cap_cycle_p4", c, 2065);
        sb.push_back('{mk(24'h5A5A5A, 24'hA5A5A5), 1'b0}); last_tx = mk(24'h5A5A5A, 24'hA5A5A5);
        send(24'hC3C3C3, 24'h3C3C3C, c); check("cap_cycle_p5", c, 3089);
        sb.push_back('{mk(24'hC3C3C3, 24'h3C3C3C), 1'b0}); last_tx = mk(24'hC3C3C3, 24'h3C3C3C);

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        ur_frame = last_tx;
`else
        ur_frame = '0;
`endif
        // Frame 5 underruns; frame 6 underruns while capturing on its load edge.
        sb.push_back('{ur_frame, 1'b1});
        sb.push_back('{ur_frame, 1'b1});
        wait_until(6159);
        send(24'h0F0F0F, 24'hF0F0F0, c); check("cap_cycle_simultaneous", c, 6160);
        check("simultaneous_underrun", out_underrun, 1);
        sb.push_back('{mk(24'h0F0F0F, 24'hF0F0F0), 1'b0}); last_tx = mk(24'h0F0F0F, 24'hF0F0F0);

        // Buffer a pair for frame 8, then reset mid-frame 7 at bit_cnt 40.
        send(24'h111111, 24'h222222, c); check("cap_cycle_p7", c, 7185);
        wait_until(7824);
        check("sb_pending_before_rst", sb.size(), 1);
        check("ready_before_rst", out_ready, 0);
        check("lrck_before_rst", out_lrck, 1);
        in_rst = 1'b1;
        tick();
        check("midrst_bck", out_bck, 0);
        check("midrst_lrck", out_lrck, 1);
        check("midrst_sdata", out_sdata, 0);
        check("midrst_ready", out_ready, 1);
        check("midrst_underrun", out_underrun, 0);
        sb.delete();
        last_tx = '0;
        in_rst  = 1'b0;
        sb.push_back('{64'h0, 1'b1});
        wait_until(1040);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
